// File: rtl/fpga_rst_seq.sv
`default_nettype none
// ============================================================================
// fpga_rst_seq : board reset sequencer (button debounce, MIG reset, SoC stretch)
// Revision: 1.0
// ============================================================================
module fpga_rst_seq #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DRAM_RST_CYCLES = 64,
  parameter int CALIB_TIMEOUT   = 2**24,
  parameter int STRETCH_CYCLES  = 32,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_WIDTH       = 24
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_rst_i,
  input  logic       vio_rst_i,
  input  logic       calib_done_i,
  output logic       dram_sys_rst_o,
  output logic       soc_rst_no,
  output logic       calib_err_o,
  output logic [1:0] retry_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] c_db_last      = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_dram_last    = CNT_WIDTH'(DRAM_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_calib_last   = CNT_WIDTH'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] c_stretch_last = CNT_WIDTH'(STRETCH_CYCLES - 1);
  localparam logic [1:0]           c_max_retries  = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST_DRAM   = 3'd0,
    ST_WAIT_CALIB = 3'd1,
    ST_STRETCH    = 3'd2,
    ST_RUN        = 3'd3,
    ST_ERROR      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           retry_q, retry_d;
  logic [1:0]           btn_sync_q, btn_sync_d;
  logic [1:0]           vio_sync_q, vio_sync_d;
  logic [1:0]           cal_sync_q, cal_sync_d;
  logic                 btn_db_q, btn_db_d;

  logic btn_s, vio_s, cal_s, rst_req;

  assign btn_s   = btn_sync_q[1];
  assign vio_s   = vio_sync_q[1];
  assign cal_s   = cal_sync_q[1];
  assign rst_req = btn_db_q | vio_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RST_DRAM;
      cnt_q      <= '0;
      db_cnt_q   <= '0;
      retry_q    <= '0;
      btn_sync_q <= '0;
      vio_sync_q <= '0;
      cal_sync_q <= '0;
      btn_db_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_cnt_q   <= db_cnt_d;
      retry_q    <= retry_d;
      btn_sync_q <= btn_sync_d;
      vio_sync_q <= vio_sync_d;
      cal_sync_q <= cal_sync_d;
      btn_db_q   <= btn_db_d;
    end
  end

  // Synchronizers and button debounce: the accepted level only flips after a
  // full window of uninterrupted disagreement.
  always_comb begin
    btn_sync_d = {btn_sync_q[0], btn_rst_i};
    vio_sync_d = {vio_sync_q[0], vio_rst_i};
    cal_sync_d = {cal_sync_q[0], calib_done_i};
    btn_db_d   = btn_db_q;
    db_cnt_d   = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == c_db_last) begin
        btn_db_d = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_WIDTH'(1);
    retry_d = retry_q;
    if (rst_req) begin
      state_d = ST_RST_DRAM;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST_DRAM: begin
          if (cnt_q == c_dram_last) begin
            state_d = ST_WAIT_CALIB;
            cnt_d   = '0;
          end
        end
        ST_WAIT_CALIB: begin
          // Calibration completing on the timeout cycle takes precedence.
          if (cal_s) begin
            state_d = ST_STRETCH;
            cnt_d   = '0;
          end else if (cnt_q == c_calib_last) begin
            cnt_d = '0;
            if (retry_q == c_max_retries) begin
              state_d = ST_ERROR;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = ST_RST_DRAM;
            end
          end
        end
        ST_STRETCH: begin
          if (!cal_s) begin
            state_d = ST_WAIT_CALIB;
            cnt_d   = '0;
          end else if (cnt_q == c_stretch_last) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = '0;
          if (!cal_s) begin
            state_d = ST_RST_DRAM;
          end
        end
        ST_ERROR: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RST_DRAM;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dram_sys_rst_o = (state_q == ST_RST_DRAM) || (state_q == ST_ERROR);
    soc_rst_no     = (state_q == ST_RUN);
    calib_err_o    = (state_q == ST_ERROR);
    retry_cnt_o    = retry_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fpga_rst_seq.sv
`default_nettype none
// ============================================================================
// tb_fpga_rst_seq : directed bench with a phase-level reference model
// Revision: 1.0
// ============================================================================
module tb_fpga_rst_seq;

  localparam int DB = 8;
  localparam int DR = 4;
  localparam int ST = 8;
  localparam int CT = 100;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn = 1'b0;
  logic       vio = 1'b0;
  logic       calib = 1'b1;
  logic       dram_rst;
  logic       soc_rst_n;
  logic       calib_err;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  fpga_rst_seq #(
    .DEBOUNCE_CYCLES(DB),
    .DRAM_RST_CYCLES(DR),
    .CALIB_TIMEOUT  (CT),
    .STRETCH_CYCLES (ST),
    .MAX_RETRIES    (MR),
    .CNT_WIDTH      (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .btn_rst_i     (btn),
    .vio_rst_i     (vio),
    .calib_done_i  (calib),
    .dram_sys_rst_o(dram_rst),
    .soc_rst_no    (soc_rst_n),
    .calib_err_o   (calib_err),
    .retry_cnt_o   (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: phases 0 hold DRAM reset, 1 await calibration,
  // 2 stretch, 3 running, 4 failed.
  int   m_phase = 0;
  int   m_elapsed = 0;
  int   m_retries = 0;
  int   m_diff = 0;
  logic m_btn_acc = 1'b0;
  logic [1:0] m_btn_h = '0, m_vio_h = '0, m_cal_h = '0;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      m_phase <= 0; m_elapsed <= 0; m_retries <= 0; m_diff <= 0;
      m_btn_acc <= 1'b0; m_btn_h <= '0; m_vio_h <= '0; m_cal_h <= '0;
    end else begin
      m_btn_h <= {m_btn_h[0], btn};
      m_vio_h <= {m_vio_h[0], vio};
      m_cal_h <= {m_cal_h[0], calib};
      if (m_btn_h[1] == m_btn_acc) m_diff <= 0;
      else if (m_diff + 1 == DB) begin m_btn_acc <= ~m_btn_acc; m_diff <= 0; end
      else m_diff <= m_diff + 1;

      if (m_btn_acc || m_vio_h[1]) begin
        m_phase <= 0; m_elapsed <= 0; m_retries <= 0;
      end else if (m_phase == 0) begin
        if (m_elapsed + 1 == DR) begin m_phase <= 1; m_elapsed <= 0; end
        else m_elapsed <= m_elapsed + 1;
      end else if (m_phase == 1) begin
        if (m_cal_h[1]) begin m_phase <= 2; m_elapsed <= 0; end
        else if (m_elapsed + 1 == CT) begin
          m_elapsed <= 0;
          if (m_retries >= MR) m_phase <= 4;
          else begin m_phase <= 0; m_retries <= m_retries + 1; end
        end else m_elapsed <= m_elapsed + 1;
      end else if (m_phase == 2) begin
        if (!m_cal_h[1]) begin m_phase <= 1; m_elapsed <= 0; end
        else if (m_elapsed + 1 == ST) begin m_phase <= 3; m_elapsed <= 0; end
        else m_elapsed <= m_elapsed + 1;
      end else if (m_phase == 3) begin
        if (!m_cal_h[1]) begin m_phase <= 0; m_elapsed <= 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("cmp_dram_rst", int'(dram_rst), int'(m_phase == 0 || m_phase == 4));
      chk("cmp_soc_rst_n", int'(soc_rst_n), int'(m_phase == 3));
      chk("cmp_calib_err", int'(calib_err), int'(m_phase == 4));
      chk("cmp_retry", int'(retry_cnt), m_retries);
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dram", int'(dram_rst), 1);
    chk("rst_soc", int'(soc_rst_n), 0);
    chk("rst_err", int'(calib_err), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    tick(3);
    rst_n = 1'b1;

    // Power-up latency with calibration already done
    tick(3);  chk("pwr_dram_e3", int'(dram_rst), 1);
    tick(1);  chk("pwr_dram_e4", int'(dram_rst), 0);
    tick(8);  chk("pwr_soc_e12", int'(soc_rst_n), 0);
    tick(1);  chk("pwr_soc_e13", int'(soc_rst_n), 1);
    chk("pwr_retry", int'(retry_cnt), 0);

    // Short bounce ignored, long press accepted
    tick(3);
    btn = 1'b1; tick(5); btn = 1'b0;
    tick(15); chk("bounce_soc", int'(soc_rst_n), 1);
    btn = 1'b1;
    tick(10); chk("press_soc_p10", int'(soc_rst_n), 1);
    tick(1);  chk("press_soc_p11", int'(soc_rst_n), 0);
    chk("press_dram_p11", int'(dram_rst), 1);
    tick(1);  btn = 1'b0;
    tick(30); chk("press_recover", int'(soc_rst_n), 1);

    // Calibration lost for good: retries then ERROR
    calib = 1'b0;
    tick(3);   chk("retry0_dram", int'(dram_rst), 1);
    chk("retry0_cnt", int'(retry_cnt), 0);
    tick(103); chk("wait1_dram", int'(dram_rst), 0);
    tick(1);   chk("retry1_dram", int'(dram_rst), 1);
    chk("retry1_cnt", int'(retry_cnt), 1);
    tick(104); chk("retry2_cnt", int'(retry_cnt), 2);
    tick(103); chk("pre_err", int'(calib_err), 0);
    tick(1);   chk("err_set", int'(calib_err), 1);
    chk("err_dram", int'(dram_rst), 1);
    chk("err_retry", int'(retry_cnt), 2);
    tick(50);  chk("err_sticky", int'(calib_err), 1);
    vio = 1'b1;
    tick(3);   chk("vio_err_clr", int'(calib_err), 0);
    chk("vio_retry_clr", int'(retry_cnt), 0);
    vio = 1'b0; calib = 1'b1;
    tick(20);  chk("vio_run", int'(soc_rst_n), 1);

    // One-cycle calibration glitch during the stretch
    vio = 1'b1; tick(1); vio = 1'b0;
    tick(9);  calib = 1'b0;
    tick(1);  calib = 1'b1;
    tick(5);  chk("glitch_no_early", int'(soc_rst_n), 0);
    tick(5);  chk("glitch_a21", int'(soc_rst_n), 0);
    tick(1);  chk("glitch_a22", int'(soc_rst_n), 1);

    // Calibration lost while running
    calib = 1'b0;
    tick(2);  chk("run_loss_b2", int'(soc_rst_n), 1);
    tick(1);  chk("run_loss_b3_soc", int'(soc_rst_n), 0);
    chk("run_loss_b3_dram", int'(dram_rst), 1);
    calib = 1'b1;
    tick(3);  chk("run_loss_b6", int'(dram_rst), 1);
    tick(1);  chk("run_loss_b7", int'(dram_rst), 0);

    // Asynchronous reset in the middle of the stretch
    tick(3);  chk("stretch_dram", int'(dram_rst), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dram", int'(dram_rst), 1);
    chk("async_soc", int'(soc_rst_n), 0);
    chk("async_retry", int'(retry_cnt), 0);
    tick(2);  rst_n = 1'b1;
    tick(20); chk("final_run", int'(soc_rst_n), 1);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpga_rst_seq.md
Name: fpga_rst_seq

Overview:
- Board-level reset sequencer for the FPGA top. Sits directly upstream of the DRAM MIG wrapper and the SoC reset generator.
- Debounces the raw board reset button and merges it with the optional VIO reset.
- Drives the MIG system reset, waits for DRAM calibration with timeout and retry, then releases a stretched SoC reset.
- Replaces the direct cpu_reset/vio_reset OR that feeds the DRAM wrapper.

Parameters:
- DebounceCycles, 50000, cycles a synchronized button level must be stable before it is accepted (1 ms at 50 MHz).
- DramRstCycles, 64, minimum cycles the MIG system reset is held high.
- CalibTimeout, 2**24, cycles allowed in WAIT_CALIB before a retry.
- StretchCycles, 32, cycles the SoC reset stays low after calibration is done.
- MaxRetries, 3, DRAM reset retries before entering ERROR; range 0..3.
- CntWidth, 24, shared counter width; must satisfy 2**CntWidth >= max(DebounceCycles, DramRstCycles, CalibTimeout, StretchCycles).

Ports:
- clk_i, in, 1, free-running board clock.
- rst_ni, in, 1, asynchronous active-low reset (power-on).
- btn_rst_i, in, 1, raw board reset button, active-high, asynchronous and bouncy.
- vio_rst_i, in, 1, VIO reset request, active-high, asynchronous.
- calib_done_i, in, 1, MIG init_calib_complete, asynchronous.
- dram_sys_rst_o, out, 1, active-high MIG system reset.
- soc_rst_no, out, 1, active-low SoC reset.
- calib_err_o, out, 1, sticky calibration failure flag.
- retry_cnt_o, out, 2, number of retries performed since the last reset request.

Behaviour:
- Reset (rst_ni=0), all asserted asynchronously:
  - state=RST_DRAM; all counters=0; sync flops=0; debounced button=0.
  - dram_sys_rst_o=1, soc_rst_no=0, calib_err_o=0, retry_cnt_o=0.
- Synchronizers: btn_rst_i, vio_rst_i and calib_done_i each pass through a 2-FF synchronizer. Their outputs are btn_s, vio_s and cal_s.
- Debounce:
  - db_cnt increments while btn_s != btn_db and clears when they are equal.
  - When db_cnt == DebounceCycles-1 and btn_s still differs, btn_db toggles and db_cnt clears.
  - A bounce shorter than DebounceCycles never changes btn_db.
- rst_req = btn_db | vio_s. VIO is not debounced.
- All outputs decode directly from registered state and counters; no combinational path from any input to any output.
- FSM; rst_req=1 has top priority in every state:
  - rst_req=1 in any state: next state RST_DRAM, cnt=0, retry=0, calib_err cleared. RST_DRAM holds with cnt=0 while rst_req=1.
  - RST_DRAM: dram_sys_rst_o=1, soc_rst_no=0. cnt counts up; at cnt==DramRstCycles-1 go to WAIT_CALIB with cnt=0.
  - WAIT_CALIB: dram_sys_rst_o=0, soc_rst_no=0.
    - If cal_s=1, go to STRETCH with cnt=0.
    - Otherwise, at cnt==CalibTimeout-1: if retry==MaxRetries go to ERROR; otherwise retry+=1 and go to RST_DRAM with cnt=0.
  - STRETCH: soc_rst_no=0.
    - cal_s=0 returns to WAIT_CALIB with cnt=0.
    - At cnt==StretchCycles-1 go to RUN.
  - RUN: soc_rst_no=1, dram_sys_rst_o=0. cal_s=0 goes to RST_DRAM with cnt=0; retry is not cleared.
  - ERROR: dram_sys_rst_o=1, soc_rst_no=0, calib_err_o=1. Exits only on rst_req=1.
- Latency with calib_done_i already high and no request: soc_rst_no rises after exactly DramRstCycles+StretchCycles+1 rising edges following rst_ni release.
- Simultaneous events:
  - rst_req and a timeout in the same cycle: rst_req wins and retry goes to 0.
  - cal_s rising on the timeout cycle: calibration wins and the FSM goes to STRETCH.
- The retry counter saturates at MaxRetries.

Test Plan (params DebounceCycles=8, DramRstCycles=4, StretchCycles=8, CalibTimeout=100, MaxRetries=2):
- Release rst_ni with calib_done_i=1 -> dram_sys_rst_o falls at edge 4; soc_rst_no rises at edge 13; retry_cnt_o=0.
- In RUN, btn_rst_i pulses 5 cycles, then a 12-cycle press -> 5-cycle pulse has no effect; 12-cycle press drops soc_rst_no and raises dram_sys_rst_o 2+8 cycles after press start.
- calib_done_i held 0 -> three DRAM reset pulses (initial plus 2 retries); retry_cnt_o steps 0,1,2; calib_err_o=1 after 3*(4+100) cycles; outputs stay in ERROR; vio_rst_i pulse clears calib_err_o and retry_cnt_o.
- calib_done_i drops for 1 cycle in STRETCH -> return to WAIT_CALIB; soc_rst_no stays 0 until a full 8-cycle stretch completes.
- calib_done_i drops in RUN -> soc_rst_no=0 within 3 cycles and dram_sys_rst_o=1 for 4 cycles.
- rst_ni asserted mid-STRETCH -> outputs immediately take reset values, with no clock required.
